ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register outputs (funct, RD1, RD2) alongside the main ALU.
- Owns the architectural HI/LO registers and executes MULTU/DIVU, MTHI/MTLO and MFHI/MFLO.
- Raises a stall that freezes PC, IF/ID and ID/EX while an operation iterates.

Parameters:
- XLEN, 32, operand/HI/LO width; iteration count equals XLEN.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; clock clk
- op_valid  in  1  EX holds a valid R-type instruction (from the ID/EX EX control field)
- funct  in  6  funct field from ID/EX
- src_a  in  XLEN  RS operand (RD1 from ID/EX, post-forwarding)
- src_b  in  XLEN  RT operand (RD2 from ID/EX, post-forwarding)
- stall  out  1  hold PC, IF/ID and ID/EX; insert bubble into EX/MEM
- hi  out  XLEN  HI register
- lo  out  XLEN  LO register
- mf_result  out  XLEN  MFHI→hi, MFLO→lo, otherwise 0; combinational
- mf_sel  out  1  op_valid & funct in {MFHI, MFLO}; steers the EX result mux

Behaviour:
- Funct codes:
  - MULTU 6'h19, DIVU 6'h1B
  - MFHI 6'h10, MTHI 6'h11, MFLO 6'h12, MTLO 6'h13
  - MULT 6'h18, DIV 6'h1A (optional feature only)
- start_cond = op_valid & state==IDLE & funct is a multiply/divide code.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE → MUL/DIV on start_cond: latch operands, count←0.
  - MUL/DIV: one iteration per cycle; after count==XLEN-1, write HI/LO and go to DONE.
  - DONE → IDLE unconditionally.
- stall = start_cond | state==MUL | state==DIV. stall is 0 in DONE.
- Timing: accept cycle N, stall high cycles N..N+XLEN (33 cycles at 32). HI/LO are valid from cycle N+XLEN+1 (DONE). ID/EX advances at the end of DONE.
- DONE exists so the same held instruction is not re-accepted. A mul/div directly following enters EX only after DONE, finds IDLE and starts.
- MULTU: shift-add over a 2·XLEN accumulator; {HI,LO} = src_a*src_b.
- DIVU: restoring, one quotient bit per cycle; LO = quotient, HI = remainder.
- DIVU with src_b=0: LO = all ones, HI = src_a; the full XLEN cycles still elapse.
- MTHI/MTLO: when op_valid & IDLE, HI/LO ← src_a at the clock edge; no stall.
- MFHI/MFLO read registered HI/LO. There is no internal bypass, and none is needed: the MT → MF distance is at least 1 cycle.
- Operand changes on src_a/src_b during MUL/DIV are ignored (latched copies are used).
- Unlisted funct codes: no stall; HI/LO unchanged.
- rst (any state, including mid-iteration): state=IDLE, count=0, hi=0, lo=0, stall=0, internal accumulators cleared. The aborted operation never writes HI/LO.

Optional Feature:
- Macro MULDIV_SIGNED_EN.
- Defined:
  - MULT/DIV are accepted like MULTU/DIVU.
  - Operands are converted to magnitudes at accept; the unsigned datapath runs the same XLEN cycles.
  - Sign fix is applied when writing HI/LO:
    - product negated if operand signs differ
    - quotient negated if signs differ
    - remainder takes the dividend's sign
  - Signed divide by zero: HI = src_a; LO = 32'hFFFFFFFF if src_a ≥ 0, else 32'h00000001.
- Undefined: MULT/DIV are treated as unlisted codes (no stall, HI/LO unchanged); no sign logic is synthesized.

Test Plan:
- MULTU src_a=32'hFFFFFFFF, src_b=32'hFFFFFFFF → stall high exactly 33 cycles; HI=32'hFFFFFFFE, LO=32'h00000001 in DONE; stall low in DONE.
- DIVU 100/7 → LO=14, HI=2. Then DIVU 5/0 → LO=32'hFFFFFFFF, HI=5, still 33 stall cycles.
- MTHI src_a=32'hDEADBEEF, then MFHI next cycle → no stall; mf_sel=1, mf_result=32'hDEADBEEF. MFLO returns the previous LO.
- MULTU accepted, rst pulsed on the 10th MUL cycle → next cycle stall=0, hi=lo=0, state IDLE. A fresh MULTU 3*4 then gives LO=12, HI=0.
- Back-to-back MULTU 2*3 then DIVU 9/4, op_valid held across the stall → two distinct operations with a single DONE cycle between them; LO=2, HI=1 after the second.
- With MULDIV_SIGNED_EN: MULT -3*5 → HI=32'hFFFFFFFF, LO=32'hFFFFFFF1; DIV -7/2 → LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. Without the macro: MULT → no stall, HI/LO unchanged.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative EX-stage multiply/divide unit owning HI/LO (MULTU/DIVU, MTHI/MTLO, MFHI/MFLO).
// Define MULDIV_SIGNED_EN to also accept signed MULT/DIV on the same unsigned datapath.
module ex_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    input  logic [5:0]      funct,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            stall,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] mf_result,
    output logic            mf_sel
);

    localparam int unsigned CW = $clog2(XLEN);

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       count;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     opnd;
    logic                is_signed;
    logic                is_mul;
    logic                is_div;
    logic                start_cond;
    logic                last;
    logic [XLEN-1:0]     a_mag;
    logic [XLEN-1:0]     b_mag;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_nxt;
    logic [XLEN:0]       div_diff;
    logic                div_ok;
    logic [2*XLEN-1:0]   div_nxt;
    logic [XLEN-1:0]     res_hi;
    logic [XLEN-1:0]     res_lo;

`ifdef MULDIV_SIGNED_EN
    logic neg_res;
    logic neg_rem;
    assign is_signed = (funct == F_MULT) || (funct == F_DIV);
    assign a_mag     = (is_signed && src_a[XLEN-1]) ? -src_a : src_a;
    assign b_mag     = (is_signed && src_b[XLEN-1]) ? -src_b : src_b;
`else
    assign is_signed = 1'b0;
    assign a_mag     = src_a;
    assign b_mag     = src_b;
`endif

    assign is_mul     = (funct == F_MULTU) || (is_signed && funct == F_MULT);
    assign is_div     = (funct == F_DIVU)  || (is_signed && funct == F_DIV);
    assign start_cond = op_valid && (state == S_IDLE) && (is_mul || is_div);
    assign last       = (count == CW'(XLEN - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_cond) state_nxt = is_mul ? S_MUL : S_DIV;
            S_MUL:   if (last) state_nxt = S_DONE;
            S_DIV:   if (last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs: stall covers the accept cycle plus every iteration; DONE releases the pipe
    always_comb begin
        stall     = start_cond || (state == S_MUL) || (state == S_DIV);
        mf_sel    = op_valid && ((funct == F_MFHI) || (funct == F_MFLO));
        mf_result = '0;
        if (funct == F_MFHI) mf_result = hi;
        if (funct == F_MFLO) mf_result = lo;
    end

    // Shift-add multiply step: acc = {partial product, remaining multiplier bits}
    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_nxt = {mul_sum, acc[XLEN-1:1]};

    // Restoring divide step: acc = {remainder, dividend bits / quotient bits}
    assign div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    assign div_ok   = ~div_diff[XLEN];
    assign div_nxt  = {div_ok ? div_diff[XLEN-1:0] : acc[2*XLEN-2:XLEN-1],
                       acc[XLEN-2:0], div_ok};

    // Final HI/LO values, sign-corrected for signed operations
    always_comb begin
        res_hi = (state == S_MUL) ? mul_nxt[2*XLEN-1:XLEN] : div_nxt[2*XLEN-1:XLEN];
        res_lo = (state == S_MUL) ? mul_nxt[XLEN-1:0]      : div_nxt[XLEN-1:0];
`ifdef MULDIV_SIGNED_EN
        if (state == S_MUL) begin
            if (neg_res) {res_hi, res_lo} = -mul_nxt;
        end else begin
            if (neg_res) res_lo = -div_nxt[XLEN-1:0];
            if (neg_rem) res_hi = -div_nxt[2*XLEN-1:XLEN];
        end
`endif
    end

    // Datapath and architectural HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            acc   <= '0;
            opnd  <= '0;
            hi    <= '0;
            lo    <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
`endif
        end else begin
            if (op_valid && state == S_IDLE) begin
                if (funct == F_MTHI) hi <= src_a;
                if (funct == F_MTLO) lo <= src_a;
            end
            if (start_cond) begin
                count <= '0;
                if (is_mul) begin
                    acc  <= {XLEN'(0), b_mag};
                    opnd <= a_mag;
                end else begin
                    acc  <= {XLEN'(0), a_mag};
                    opnd <= b_mag;
                end
`ifdef MULDIV_SIGNED_EN
                neg_res <= is_signed && (src_a[XLEN-1] ^ src_b[XLEN-1]);
                neg_rem <= is_signed && src_a[XLEN-1];
`endif
            end
            if (state == S_MUL || state == S_DIV) begin
                acc   <= (state == S_MUL) ? mul_nxt : div_nxt;
                count <= count + CW'(1);
                if (last) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: vector table, hand sequences, randomized ops vs a plain-arithmetic model.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [5:0]  funct;
    logic [31:0] src_a, src_b;
    logic        stall;
    logic [31:0] hi, lo, mf_result;
    logic        mf_sel;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi, exp_lo;

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .funct(funct),
        .src_a(src_a), .src_b(src_b), .stall(stall), .hi(hi), .lo(lo),
        .mf_result(mf_result), .mf_sel(mf_sel)
    );

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a, b, hi, lo;
        int          cyc;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: architectural effect of one instruction; returns expected stall cycles
    function automatic int model_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb, q, r;
        case (f)
            6'h19: begin p = {32'b0, a} * {32'b0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; return 33; end
            6'h1B: begin
                if (b == 0) begin exp_hi = a; exp_lo = 32'hFFFFFFFF; end
                else begin exp_lo = a / b; exp_hi = a % b; end
                return 33;
            end
            6'h11: begin exp_hi = a; return 0; end
            6'h13: begin exp_lo = a; return 0; end
`ifdef MULDIV_SIGNED_EN
            6'h18: begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
                p = 64'(sa * sb); exp_hi = p[63:32]; exp_lo = p[31:0]; return 33;
            end
            6'h1A: begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
                if (b == 0) begin exp_hi = a; exp_lo = (sa >= 0) ? 32'hFFFFFFFF : 32'h1; end
                else begin q = sa / sb; r = sa % sb; exp_lo = 32'(q); exp_hi = 32'(r); end
                return 33;
            end
`endif
            default: return 0;
        endcase
    endfunction

    // Issue one instruction, hold it through its stall (scrambling operands), return DONE-cycle HI/LO
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output logic [31:0] h, output logic [31:0] l,
                          output logic msel, output logic [31:0] mres);
        @(negedge clk);
        op_valid = 1'b1; funct = f; src_a = a; src_b = b;
        #1;
        msel = mf_sel; mres = mf_result;
        cyc = 0;
        for (int i = 0; i < 64 && stall; i++) begin
            cyc++;
            @(negedge clk);
            src_a = $urandom; src_b = $urandom;
            #1;
        end
        if (stall) $display("FAIL stall_timeout actual=%0d required=33", cyc);
        if (cyc == 0) begin
            @(negedge clk);
            op_valid = 1'b0;
            #1;
        end
        h = hi; l = lo;
    endtask

    initial begin
        int          cyc, ecyc;
        logic [31:0] h, l, mres, a, b;
        logic        msel;
        logic [5:0]  pool[9];
        logic [5:0]  f;

        pool = '{6'h19, 6'h1B, 6'h11, 6'h13, 6'h10, 6'h12, 6'h20, 6'h18, 6'h1A};

        tbl[0]  = '{6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
        tbl[1]  = '{6'h1B, 32'd100, 32'd7, 32'd2, 32'd14, 33};
        tbl[2]  = '{6'h1B, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 33};
        tbl[3]  = '{6'h11, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'hFFFFFFFF, 0};
        tbl[4]  = '{6'h13, 32'h12345678, 32'h0, 32'hDEADBEEF, 32'h12345678, 0};
`ifdef MULDIV_SIGNED_EN
        tbl[5]  = '{6'h18, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 33};
        tbl[6]  = '{6'h1A, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        tbl[7]  = '{6'h20, 32'h1, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0};
`else
        tbl[5]  = '{6'h18, 32'hFFFFFFFD, 32'd5, 32'hDEADBEEF, 32'h12345678, 0};
        tbl[6]  = '{6'h1A, 32'hFFFFFFF9, 32'd2, 32'hDEADBEEF, 32'h12345678, 0};
        tbl[7]  = '{6'h20, 32'h1, 32'h2, 32'hDEADBEEF, 32'h12345678, 0};
`endif
        tbl[8]  = '{6'h1B, 32'd7, 32'd9, 32'd7, 32'd0, 33};
        tbl[9]  = '{6'h1B, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 33};
        tbl[10] = '{6'h19, 32'd0, 32'h1234, 32'd0, 32'd0, 33};
        tbl[11] = '{6'h1B, 32'h80000000, 32'h80000000, 32'd0, 32'd1, 33};

        rst = 1'b1; op_valid = 1'b0; funct = 6'h0; src_a = '0; src_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_mf_sel", 32'(mf_sel), 32'h0);

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].f, tbl[i].a, tbl[i].b, cyc, h, l, msel, mres);
            chk($sformatf("vec%0d_stall_cycles", i), 32'(cyc), 32'(tbl[i].cyc));
            chk($sformatf("vec%0d_hi", i), h, tbl[i].hi);
            chk($sformatf("vec%0d_lo", i), l, tbl[i].lo);
            exp_hi = tbl[i].hi; exp_lo = tbl[i].lo;
        end

        // MTHI immediately followed by MFHI, then MFLO
        @(negedge clk);
        op_valid = 1'b1; funct = 6'h11; src_a = 32'hDEADBEEF; #1;
        chk("mthi_stall", 32'(stall), 32'h0);
        @(negedge clk);
        funct = 6'h10; src_a = 32'h0; #1;
        chk("mfhi_stall", 32'(stall), 32'h0);
        chk("mfhi_sel", 32'(mf_sel), 32'h1);
        chk("mfhi_result", mf_result, 32'hDEADBEEF);
        @(negedge clk);
        funct = 6'h12; #1;
        chk("mflo_sel", 32'(mf_sel), 32'h1);
        chk("mflo_result", mf_result, exp_lo);
        exp_hi = 32'hDEADBEEF;
        @(negedge clk);
        op_valid = 1'b0;

        // Back-to-back with op_valid held across the stall
        run_op(6'h19, 32'd2, 32'd3, cyc, h, l, msel, mres);
        chk("b2b_mul_cycles", 32'(cyc), 32'd33);
        chk("b2b_mul_hi", h, 32'd0);
        chk("b2b_mul_lo", l, 32'd6);
        run_op(6'h1B, 32'd9, 32'd4, cyc, h, l, msel, mres);
        chk("b2b_div_cycles", 32'(cyc), 32'd33);
        chk("b2b_div_hi", h, 32'd1);
        chk("b2b_div_lo", l, 32'd2);

        // Reset during the 10th MUL cycle aborts the operation
        @(negedge clk);
        op_valid = 1'b1; funct = 6'h19; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
        repeat (10) @(negedge clk);
        #1;
        chk("mid_mul_stall", 32'(stall), 32'h1);
        rst = 1'b1; op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0; #1;
        chk("abort_stall", 32'(stall), 32'h0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        run_op(6'h19, 32'd3, 32'd4, cyc, h, l, msel, mres);
        chk("post_rst_cycles", 32'(cyc), 32'd33);
        chk("post_rst_hi", h, 32'd0);
        chk("post_rst_lo", l, 32'd12);
        exp_hi = 32'd0; exp_lo = 32'd12;

        // Randomized instruction stream against the model
        for (int n = 0; n < 60; n++) begin
            f = pool[$urandom_range(0, 8)];
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            if (f == 6'h10 || f == 6'h12) begin
                run_op(f, a, b, cyc, h, l, msel, mres);
                chk($sformatf("rnd%0d_mf_sel", n), 32'(msel), 32'h1);
                chk($sformatf("rnd%0d_mf_result", n), mres, (f == 6'h10) ? exp_hi : exp_lo);
            end else begin
                ecyc = model_op(f, a, b);
                run_op(f, a, b, cyc, h, l, msel, mres);
                chk($sformatf("rnd%0d_mf_sel", n), 32'(msel), 32'h0);
            end
            chk($sformatf("rnd%0d_f%h_cycles", n, f), 32'(cyc),
                (f == 6'h10 || f == 6'h12) ? 32'h0 : 32'(ecyc));
            chk($sformatf("rnd%0d_f%h_hi", n, f), h, exp_hi);
            chk($sformatf("rnd%0d_f%h_lo", n, f), l, exp_lo);
        end

        @(negedge clk);
        op_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
